// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles 5-byte UART command frames, updates PWM duty/enable and queues responses
module uart_cmd_decoder #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter logic [15:0] DUTY_MAX       = 16'd10000,
    parameter logic [15:0] DUTY_RESET     = 16'd5000,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_stop_ok,
    output logic [15:0] duty,
    output logic        duty_update,
    output logic        pwm_en,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [7:0]  err_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, CHK, EXEC, RESP} state_t;

    state_t state, nxt;
    logic [7:0] cmd_q, dhi_q, dlo_q, chk_q;
    logic [TW-1:0] timer;
    logic [15:0] rd_buf;
    logic [1:0] rem;
    logic in_frame, byte_ok, frame_err, timeout, exec_ack, err_inc;

    // Frame decode, error detection and next-state selection
    always_comb begin
        in_frame  = state inside {CMD, DHI, DLO, CHK};
        frame_err = in_frame && rx_valid && !rx_stop_ok;
        byte_ok   = in_frame && rx_valid && rx_stop_ok;
        timeout   = in_frame && !rx_valid && timer == TW'(TIMEOUT_CYCLES);
        exec_ack  = chk_q == (cmd_q ^ dhi_q ^ dlo_q) &&
                    (cmd_q == 8'h01 ? {dhi_q, dlo_q} <= DUTY_MAX : cmd_q == 8'h02 || cmd_q == 8'h03);
        err_inc   = frame_err || timeout || (state == EXEC && !exec_ack);
        nxt       = state;
        case (state)
            IDLE:    nxt = rx_valid && rx_stop_ok && rx_data == HEADER ? CMD : IDLE;
            EXEC:    nxt = RESP;
            RESP:    nxt = tx_ready && rem == 2'd0 ? IDLE : RESP;
            default: nxt = frame_err || timeout ? IDLE :
                           !byte_ok ? state :
                           state == CMD ? DHI :
                           state == DHI ? DLO :
                           state == DLO ? CHK : EXEC;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : nxt;
    end

    // Inter-byte timer: restarts on every received byte and only runs mid-frame
    always_ff @(posedge clk) begin
        timer <= (!rst_n || !in_frame || rx_valid) ? '0 : timer + TW'(1);
    end

    // Byte capture, command execution, response sequencing and error counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty        <= DUTY_RESET;
            duty_update <= 1'b0;
            pwm_en      <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            err_cnt     <= 8'h00;
            cmd_q       <= 8'h00;
            dhi_q       <= 8'h00;
            dlo_q       <= 8'h00;
            chk_q       <= 8'h00;
            rd_buf      <= 16'h0000;
            rem         <= 2'd0;
        end else begin
            duty_update <= 1'b0;
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (byte_ok) begin
                if (state == CMD) cmd_q <= rx_data;
                if (state == DHI) dhi_q <= rx_data;
                if (state == DLO) dlo_q <= rx_data;
                if (state == CHK) chk_q <= rx_data;
            end
            if (state == EXEC) begin
                tx_valid <= 1'b1;
                tx_data  <= exec_ack ? ACK : NAK;
                rem      <= exec_ack && cmd_q == 8'h03 ? 2'd2 : 2'd0;
                rd_buf   <= duty;
                if (exec_ack && cmd_q == 8'h01) begin
                    duty        <= {dhi_q, dlo_q};
                    duty_update <= 1'b1;
                end
                if (exec_ack && cmd_q == 8'h02)
                    pwm_en <= dlo_q[0];
            end
            if (state == RESP && tx_ready) begin
                if (rem == 2'd0) begin
                    tx_valid <= 1'b0;
                end else begin
                    tx_data <= rd_buf[15:8];
                    rd_buf  <= {rd_buf[7:0], 8'h00};
                    rem     <= rem - 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: randomized frame stimulus checked against a frame-level reference model
module tb_uart_cmd_decoder;
    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_stop_ok = 1'b1;
    logic [15:0] duty;
    logic        duty_update;
    logic        pwm_en;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [7:0]  err_cnt;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_stop_ok(rx_stop_ok), .duty(duty), .duty_update(duty_update),
        .pwm_en(pwm_en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int m_duty = 5000;
    int m_en = 0;
    int m_err = 0;
    logic [7:0] exp_q[$];
    int mode = 0;
    bit hold_en = 1'b1;
    bit hold_pend = 1'b0;
    logic [7:0] hold_d = 8'h00;
    bit tv_prev = 1'b0;
    int tv_cyc = 0;
    int upd_cnt = 0;
    int upd_cyc = 0;
    int chk_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void bump();
        if (m_err < 255) m_err++;
    endfunction

    // Reference: decide the outcome of a complete frame from its four payload bytes
    function automatic bit model_frame(input logic [7:0] c, h, l, k);
        int v;
        bit ok;
        v = {h, l};
        if (k != (c ^ h ^ l)) ok = 1'b0;
        else if (c == 8'h01) ok = v <= 10000;
        else ok = c == 8'h02 || c == 8'h03;
        if (!ok) begin
            exp_q.push_back(8'h15);
            bump();
            return 1'b0;
        end
        exp_q.push_back(8'h06);
        if (c == 8'h01) m_duty = v;
        if (c == 8'h02) m_en = l[0];
        if (c == 8'h03) begin
            exp_q.push_back(m_duty[15:8]);
            exp_q.push_back(m_duty[7:0]);
        end
        return c == 8'h01;
    endfunction

    // TX sink: drives tx_ready each cycle, scores transferred bytes and checks hold stability
    initial forever begin
        @(negedge clk);
        if (hold_en && hold_pend) begin
            check("hold_valid", tx_valid, 1);
            check("hold_data", tx_data, hold_d);
        end
        tx_ready = mode == 0 ? 1'($urandom_range(0, 1)) : mode == 1 ? ~tx_ready : mode == 2;
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) check("tx_extra", {24'h0, tx_data}, 32'h100);
            else check("tx_byte", tx_data, exp_q.pop_front());
        end
        hold_pend = tx_valid && !tx_ready;
        hold_d = tx_data;
        if (tx_valid && !tv_prev) tv_cyc = cyc;
        tv_prev = tx_valid;
        if (duty_update) begin
            upd_cnt++;
            upd_cyc = cyc;
        end
    end

    task automatic send(input logic [7:0] b, input bit ok);
        rx_valid = 1'b1;
        rx_data = b;
        rx_stop_ok = ok;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_stop_ok = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_regs();
        check("duty", duty, m_duty);
        check("pwm_en", pwm_en, m_en);
        check("err_cnt", err_cnt, m_err);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || tx_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic frame(input logic [7:0] c, h, l, k, input bit junk, input int gap);
        int u0;
        bit upd;
        u0 = upd_cnt;
        send(8'hA5, 1); send(c, 1); send(h, 1);
        idle(gap);
        send(l, 1);
        chk_cyc = cyc;
        send(k, 1);
        upd = model_frame(c, h, l, k);
        if (junk) send(8'hA5, 1);
        drain();
        check("upd_count", upd_cnt - u0, upd);
        if (upd) check("upd_time", upd_cyc, chk_cyc + 2);
        check("tx_latency", tv_cyc, chk_cyc + 2);
        check_regs();
    endtask

    task automatic abort(input int p);
        send(8'hA5, 1);
        for (int i = 1; i < p; i++) send(8'($urandom), 1);
        send(8'($urandom), 0);
        bump();
        idle(2);
        check("abort_err", err_cnt, m_err);
        check("abort_tx", tx_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, h, l, k;
        int t;
        idle(3);
        check("rst_duty", duty, 5000);
        check("rst_upd", duty_update, 0);
        check("rst_en", pwm_en, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_txd", tx_data, 0);
        check("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        idle(2);
        mode = 2;
        frame(8'h01, 8'h13, 8'h88, 8'h9A, 0, 0);
        mode = 0;
        frame(8'h01, 8'h27, 8'h11, 8'h37, 0, 0);
        frame(8'h01, 8'h27, 8'h11, 8'h00, 0, 0);
        mode = 1;
        frame(8'h02, 8'h00, 8'h01, 8'h03, 0, 0);
        frame(8'h03, 8'h00, 8'h00, 8'h03, 0, 0);
        mode = 0;
        send(8'h11, 1); send(8'h22, 1); send(8'hA5, 0); send(8'h01, 1);
        idle(3);
        check("idle_bad_stop", err_cnt, m_err);
        send(8'hA5, 1); send(8'h01, 1); send(8'h13, 1); send(8'h88, 0);
        bump();
        idle(3);
        check("stop_err", err_cnt, m_err);
        check("stop_no_tx", tx_valid, 0);
        frame(8'h01, 8'h10, 8'h00, 8'h11, 0, 0);
        send(8'hA5, 1); send(8'h01, 1);
        idle(TO);
        check("pre_timeout", err_cnt, m_err);
        idle(1);
        bump();
        check("timeout", err_cnt, m_err);
        frame(8'h01, 8'h00, 8'h64, 8'h65, 0, TO);
        frame(8'h03, 8'h12, 8'h34, 8'h25, 1, 0);
        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(0, 9);
            c = t < 4 ? 8'h01 : t < 6 ? 8'h02 : t < 8 ? 8'h03 : 8'($urandom);
            {h, l} = $urandom_range(0, 1) ? 16'($urandom_range(9990, 10010)) : 16'($urandom);
            k = $urandom_range(0, 9) < 8 ? c ^ h ^ l : 8'($urandom);
            if ($urandom_range(0, 9) == 0) abort($urandom_range(1, 4));
            else frame(c, h, l, k, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        hold_en = 1'b0;
        mode = 3;
        send(8'hA5, 1); send(8'h03, 1); send(8'h00, 1); send(8'h00, 1); send(8'h03, 1);
        t = 0;
        while (!tx_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("resp_pending", tx_valid, 1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        exp_q.delete();
        m_duty = 5000; m_en = 0; m_err = 0;
        check("rrst_txv", tx_valid, 0);
        check_regs();
        mode = 0;
        idle(2);
        hold_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(8'hA5, 1);
            send(8'h5A, 0);
            bump();
        end
        idle(2);
        check("err_sat", err_cnt, 255);
        check("err_model", err_cnt, m_err);
        frame(8'h02, 8'h00, 8'h00, 8'h02, 0, 0);
        check("sat_hold", err_cnt, 255);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
